ring_osc_meter: RTL
===================

# ring_osc_meter

Frequency meter for the on-chip ring oscillators: it counts rising edges of one selected oscillator output over a programmable gate window of system clock cycles. The block sits downstream of the ring oscillator bank, which produces seven outputs of 3, 5, 7, 11, 13, 17 and 19 inverter stages. It reports a raw edge count that firmware converts to frequency: f_osc = count × f_clk / gate_len.

## Interface
Parameters:
- GATE_W, 16: width of gate window length.
- CNT_W, 20: width of edge counter and result.

Ports:
- clk  in  1  system clock; the only clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- osc_in  in  7  oscillator outputs, bit 0..6 = 3, 5, 7, 11, 13, 17, 19 stages; asynchronous to clk, treated as data.
- sel  in  3  oscillator select, sampled on accepted start; 7 selects constant 0.
- gate_len  in  GATE_W  measurement window in clk cycles, sampled on accepted start.
- start  in  1  request measurement; accepted only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse; count/overflow valid.
- count  out  CNT_W  rising edges counted in last window; held until next accepted start.
- overflow  out  1  count saturated in last window; held with count.

## Operation
- Every osc_in bit passes through its own 2-flop synchronizer, followed by a previous-value flop. rise[i] = sync[i] & ~prev[i].
- Selection is a mux on the rise vector, using the latched sel_q.
- FSM states:
  - IDLE: start=1 latches sel_q and gate_q, clears the edge counter and overflow, and moves to FLUSH.
  - FLUSH: 3 cycles, no counting; lets the synchronizer/prev pipeline settle → MEASURE.
  - MEASURE: counts rise on the selected input for exactly gate_q cycles; a down-counter tracks the window → DONE when it reaches 1.
  - DONE: 1 cycle; done=1, the edge counter transfers to count/overflow → IDLE.
- gate_q=0: MEASURE is skipped (FLUSH → DONE); count=0, overflow=0.
- Counter saturates at 2^CNT_W−1 and sets overflow. Further edges are ignored and never wrap.
- start while busy is ignored; no queueing.
- Changes to sel or gate_len during a measurement have no effect.
- Measurement is valid only for f_osc < f_clk/2. Faster inputs alias; the block does not detect this, and software owns the check.

## Timing
- Reset values: busy=0, done=0, count=0, overflow=0, FSM=IDLE, all synchronizer/prev flops 0.
- Start accepted at edge t:
  - busy=1 from t+1.
  - FLUSH covers t+1..t+3.
  - MEASURE covers t+4..t+3+gate_q.
  - done=1 at cycle t+4+gate_q, with count/overflow updated at the same edge.
  - busy=0 at t+5+gate_q, and start is accepted again in that cycle.
- Total latency from start to done: gate_q+4 cycles (4 when gate_q=0).
- An edge on osc_in reaches rise 3 clk edges later. Window boundaries are therefore offset by a constant 3 cycles, which FLUSH absorbs.
- Reset asserted mid-measurement: all outputs return to reset values immediately (asynchronous). The partial count is discarded and no done pulse is generated.
- The count output changes only at the DONE edge, so it is stable for reading at any other time.

## Structure
- Shared package ring_osc_pkg holds:
  - OSC_NUM=7;
  - localparams for sel encoding (SEL_03..SEL_19, SEL_OFF=7);
  - the FSM state enum (IDLE, FLUSH, MEASURE, DONE);
  - FLUSH_CYC=3.
- Sub-module osc_edge_sync: 2-flop synchronizer, previous-value flop and rise output for one bit. The top instantiates 7 copies, one per channel, so flushing after a sel change costs no extra latency beyond FLUSH.
- The top contains the FSM, window down-counter, saturating edge counter and output registers.

## Test plan
- osc_in[0] toggles every 4 clk (period 8), sel=0, gate_len=800, start → done at start+804, count=100 ±1, overflow=0.
- sel=6 with osc_in[6] period 20 clk, gate_len=1000 → count=50 ±1; toggling the other osc_in bits does not change count.
- CNT_W=4 build, osc_in[1] period 4, sel=1, gate_len=100 → count=15, overflow=1; the next run with gate_len=8 → count=2 ±1, overflow=0.
- gate_len=0, start → done exactly 4 cycles after start, count=0, overflow=0; sel=7 with gate_len=500 and all oscillators toggling → count=0.
- Pulse start again at start+10 and change sel/gate_len mid-run → ignored; the single done reflects the original settings; busy stays high throughout.
- Assert rst_n=0 at start+200 of a 1000-cycle run → count, overflow, busy and done are 0 at once; no done pulse follows; a fresh start after release gives the correct count.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring oscillator frequency meter: channel count,
// select encoding, FSM states and the synchronizer flush length.
package ring_osc_pkg;

    localparam int OSC_NUM   = 7;
    localparam int FLUSH_CYC = 3;

    localparam logic [2:0] SEL_03  = 3'd0;
    localparam logic [2:0] SEL_05  = 3'd1;
    localparam logic [2:0] SEL_07  = 3'd2;
    localparam logic [2:0] SEL_11  = 3'd3;
    localparam logic [2:0] SEL_13  = 3'd4;
    localparam logic [2:0] SEL_17  = 3'd5;
    localparam logic [2:0] SEL_19  = 3'd6;
    localparam logic [2:0] SEL_OFF = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ring_osc_meter_osc_edge_sync.sv
// One oscillator channel: 2-flop synchronizer plus a previous-value flop,
// producing a one-clk rise strobe for each rising edge seen on the input.
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/ring_osc_meter.sv
// Ring oscillator frequency meter: counts rising edges of one selected
// oscillator over a gate window of gate_len clk cycles.
module ring_osc_meter
    import ring_osc_pkg::*;
#(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        osc_in,
    input  logic [2:0]        sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          flush_cnt;
    logic [GATE_W-1:0]   win_cnt;
    logic [2:0]          sel_q;
    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                ovf_q;
    logic                ovf_nxt;
    logic [OSC_NUM-1:0]  rise;
    logic [7:0]          rise_ext;
    logic                rise_sel;

    for (genvar i = 0; i < OSC_NUM; i++) begin : g_sync
        osc_edge_sync u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (osc_in[i]),
            .rise (rise[i])
        );
    end

    // Bit 7 is the SEL_OFF slot and never strobes.
    assign rise_ext = {1'b0, rise};
    assign rise_sel = (sel_q == SEL_OFF) ? 1'b0 : rise_ext[sel_q];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = edge_cnt;
        ovf_nxt   = ovf_q;
        case (state)
            IDLE:    if (start) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == 2'd0)
                         state_nxt = (win_cnt == '0) ? DONE : MEASURE;
            MEASURE: if (win_cnt == GATE_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Saturate instead of wrapping; overflow marks a dropped edge.
        if (state == MEASURE && rise_sel) begin
            if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
            else                     cnt_nxt = edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 2'd0;
            win_cnt   <= '0;
            sel_q     <= 3'd0;
            edge_cnt  <= '0;
            ovf_q     <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                sel_q     <= sel;
                win_cnt   <= gate_len;
                flush_cnt <= 2'(FLUSH_CYC - 1);
                edge_cnt  <= '0;
                ovf_q     <= 1'b0;
            end else begin
                edge_cnt <= cnt_nxt;
                ovf_q    <= ovf_nxt;
                if (state == FLUSH && flush_cnt != 2'd0)
                    flush_cnt <= flush_cnt - 2'd1;
                if (state == MEASURE)
                    win_cnt <= win_cnt - GATE_W'(1);
            end
            if (state_nxt == DONE && state != DONE) begin
                count    <= cnt_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
